// File: rtl/layer_sequencer.sv
// Layer-by-layer feed-forward sequencer for the neural accelerator.
// Walks the instruction RAM and drives neuron/weight addresses and MAC strobes.
module layer_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int N_IN0   = 3,
  parameter int IN_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [ADDR_W-1:0] instr_data,
  output logic [ADDR_W-1:0] neuro_read_addr,
  output logic [ADDR_W-1:0] weight_read_addr,
  output logic [ADDR_W-1:0] neuro_write_addr,
  output logic              neuro_we,
  output logic              mac_clear,
  output logic              mac_acc_en,
  output logic [ADDR_W-1:0] layer_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CLEAR,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] K0    = ADDR_W'(N_IN0);
  localparam logic [ADDR_W-1:0] WB0   = ADDR_W'(IN_BASE + N_IN0);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] rbase_q, rbase_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] nk_q, nk_d;
  logic [ADDR_W-1:0] ncnt_q, ncnt_d;
  logic [ADDR_W-1:0] icnt_q, icnt_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic [ADDR_W-1:0] lidx_q, lidx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic              clr_q, clr_d;
  logic              acc_q, acc_d;

  always_comb begin
    state_d = state_q;
    rbase_d = rbase_q;
    wbase_d = wbase_q;
    k_d     = k_q;
    nk_d    = nk_q;
    ncnt_d  = ncnt_q;
    icnt_d  = icnt_q;
    iaddr_d = iaddr_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    oaddr_d = oaddr_q;
    lidx_d  = lidx_q;

    unique case (state_q)
      S_IDLE: begin
        iaddr_d = '0;
        waddr_d = '0;
        rbase_d = BASE0;
        wbase_d = WB0;
        k_d     = K0;
        lidx_d  = '0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_data == '0) begin
          state_d = S_DONE;
        end else begin
          nk_d    = instr_data;
          ncnt_d  = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        raddr_d = rbase_q;
        icnt_d  = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        raddr_d = raddr_q + ONE;
        waddr_d = waddr_q + ONE;
        icnt_d  = icnt_q + ONE;
        if (icnt_d == k_q) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (ncnt_q + ONE != nk_q) begin
          ncnt_d  = ncnt_q + ONE;
          state_d = S_CLEAR;
        end else begin
          rbase_d = wbase_q;
          wbase_d = wbase_q + nk_q;
          k_d     = nk_q;
          iaddr_d = iaddr_q + ONE;
          lidx_d  = lidx_q + ONE;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered: they describe the state being entered.
    if (state_d == S_WRITE) oaddr_d = wbase_q + ncnt_q;
    busy_d = (state_d == S_FETCH) || (state_d == S_CLEAR) ||
             (state_d == S_MAC) || (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    clr_d  = (state_d == S_CLEAR);
    acc_d  = (state_d == S_MAC);
    we_d   = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rbase_q <= '0;
      wbase_q <= '0;
      k_q     <= '0;
      nk_q    <= '0;
      ncnt_q  <= '0;
      icnt_q  <= '0;
      iaddr_q <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      oaddr_q <= '0;
      lidx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      clr_q   <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rbase_q <= rbase_d;
      wbase_q <= wbase_d;
      k_q     <= k_d;
      nk_q    <= nk_d;
      ncnt_q  <= ncnt_d;
      icnt_q  <= icnt_d;
      iaddr_q <= iaddr_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      oaddr_q <= oaddr_d;
      lidx_q  <= lidx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      clr_q   <= clr_d;
      acc_q   <= acc_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign instr_addr       = iaddr_q;
  assign neuro_read_addr  = raddr_q;
  assign weight_read_addr = waddr_q;
  assign neuro_write_addr = oaddr_q;
  assign neuro_we         = we_q;
  assign mac_clear        = clr_q;
  assign mac_acc_en       = acc_q;
  assign layer_idx        = lidx_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: bench-side MAC/RAM plus a forward-pass
// reference model; two instances cover default and wrapping bases.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] prog [256];

  always #5 clk = ~clk;

  logic       a_busy, a_done, a_we, a_clr, a_acc;
  logic [7:0] a_ia, a_id, a_ra, a_wa, a_wr, a_li;
  logic       b_busy, b_done, b_we, b_clr, b_acc;
  logic [7:0] b_ia, b_id, b_ra, b_wa, b_wr, b_li;
  logic       start_a, start_b;

  assign start_a = start && !sel;
  assign start_b = start && sel;
  assign a_id = prog[a_ia];
  assign b_id = prog[b_ia];

  layer_sequencer u_dut (
    .clk(clk), .reset(rst_n), .start(start_a),
    .busy(a_busy), .done(a_done),
    .instr_addr(a_ia), .instr_data(a_id),
    .neuro_read_addr(a_ra), .weight_read_addr(a_wa),
    .neuro_write_addr(a_wr), .neuro_we(a_we),
    .mac_clear(a_clr), .mac_acc_en(a_acc),
    .layer_idx(a_li)
  );

  layer_sequencer #(.ADDR_W(8), .N_IN0(4), .IN_BASE(252)) u_wrap (
    .clk(clk), .reset(rst_n), .start(start_b),
    .busy(b_busy), .done(b_done),
    .instr_addr(b_ia), .instr_data(b_id),
    .neuro_read_addr(b_ra), .weight_read_addr(b_wa),
    .neuro_write_addr(b_wr), .neuro_we(b_we),
    .mac_clear(b_clr), .mac_acc_en(b_acc),
    .layer_idx(b_li)
  );

  logic       m_busy, m_done, m_we, m_clr, m_acc;
  logic [7:0] m_ia, m_ra, m_wa, m_wr, m_li;

  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_we   = sel ? b_we   : a_we;
  assign m_clr  = sel ? b_clr  : a_clr;
  assign m_acc  = sel ? b_acc  : a_acc;
  assign m_ia   = sel ? b_ia   : a_ia;
  assign m_ra   = sel ? b_ra   : a_ra;
  assign m_wa   = sel ? b_wa   : a_wa;
  assign m_wr   = sel ? b_wr   : a_wr;
  assign m_li   = sel ? b_li   : a_li;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {20'd0, m_busy, m_done, m_we, m_clr, m_acc,
            m_ia, m_ra, m_wa, m_wr, m_li};
  endfunction

  int unsigned ram [256];
  int unsigned ref_ram [256];
  int unsigned wrom [256];
  int eq_r[$], eq_w[$], eq_o[$];
  int oq_r[$], oq_w[$], oq_o[$];
  int exp_busy, exp_wend, exp_nl, exp_neur;
  int busy_n, clr_n;

  task automatic load(input int p0, input int p1, input int p2,
                      input int p3, input int p4);
    foreach (prog[i]) prog[i] = 8'd0;
    prog[0] = 8'(p0);
    prog[1] = 8'(p1);
    prog[2] = 8'(p2);
    prog[3] = 8'(p3);
    prog[4] = 8'(p4);
  endtask

  task automatic rand_mem();
    foreach (ram[i]) ram[i] = $urandom_range(0, 15);
    foreach (wrom[i]) wrom[i] = $urandom_range(0, 15);
  endtask

  // Forward pass computed straight from the layer rules.
  task automatic build_expect(input int n_in0, input int in_base);
    int rb, wb, k, wp, nk;
    int unsigned s;
    eq_r.delete(); eq_w.delete(); eq_o.delete();
    ref_ram = ram;
    rb = in_base; wb = in_base + n_in0; k = n_in0; wp = 0;
    exp_busy = 1; exp_nl = 0; exp_neur = 0;
    for (int l = 0; l < 256 && prog[l] != 0; l++) begin
      nk = int'(prog[l]);
      exp_busy += 1 + nk * (k + 2);
      exp_nl++;
      for (int n = 0; n < nk; n++) begin
        s = 0;
        for (int i = 0; i < k; i++) begin
          eq_r.push_back((rb + i) % 256);
          eq_w.push_back(wp % 256);
          s += wrom[wp % 256] * ref_ram[(rb + i) % 256];
          wp++;
        end
        ref_ram[(wb + n) % 256] = s;
        eq_o.push_back((wb + n) % 256);
        exp_neur++;
      end
      rb = wb; wb = wb + nk; k = nk;
    end
    exp_wend = wp % 256;
  endtask

  task automatic run_prog(input bit hold, input int pulse_mac);
    int viol, macs, bad_ram;
    bit fin;
    int unsigned acc;
    if (sel) build_expect(4, 252);
    else build_expect(3, 0);
    oq_r.delete(); oq_w.delete(); oq_o.delete();
    viol = 0; macs = 0; fin = 0; acc = 0;
    busy_n = 0; clr_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 chk("start_lat", 64'(m_busy), 64'd1);
    if (!hold) start = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(negedge clk);
      if (m_busy) busy_n++;
      if (int'(m_clr) + int'(m_acc) + int'(m_we) > 1) viol++;
      if (m_clr) begin
        acc = 0;
        clr_n++;
      end
      if (m_acc) begin
        acc += wrom[m_wa] * ram[m_ra];
        oq_r.push_back(int'(m_ra));
        oq_w.push_back(int'(m_wa));
        macs++;
      end
      if (m_we) begin
        ram[m_wr] = acc;
        oq_o.push_back(int'(m_wr));
      end
      if (!hold) start = m_acc && (macs == pulse_mac);
      if (m_done) begin
        fin = 1;
        chk("done_busy", 64'(m_busy), 64'd0);
        chk("w_end", 64'(m_wa), 64'(exp_wend));
        chk("instr_end", 64'(m_ia), 64'(exp_nl));
        chk("layer_end", 64'(m_li), 64'(exp_nl));
      end
    end
    chk("timeout", 64'(fin), 64'd1);
    chk("excl", 64'(viol), 64'd0);
    chk("busy_cyc", 64'(busy_n), 64'(exp_busy));
    chk("clears", 64'(clr_n), 64'(exp_neur));
    chk("n_mac", 64'(oq_r.size()), 64'(eq_r.size()));
    chk("n_wr", 64'(oq_o.size()), 64'(eq_o.size()));
    for (int i = 0; i < eq_r.size() && i < oq_r.size(); i++) begin
      chk($sformatf("rd%0d", i), 64'(oq_r[i]), 64'(eq_r[i]));
      chk($sformatf("wt%0d", i), 64'(oq_w[i]), 64'(eq_w[i]));
    end
    for (int i = 0; i < eq_o.size() && i < oq_o.size(); i++)
      chk($sformatf("wa%0d", i), 64'(oq_o[i]), 64'(eq_o[i]));
    bad_ram = 0;
    foreach (ram[i]) if (ram[i] != ref_ram[i]) bad_ram++;
    chk("ram", 64'(bad_ram), 64'd0);
    @(negedge clk);
    chk("done_one", 64'(m_done), 64'd0);
    chk("idle_busy", 64'(m_busy), 64'd0);
    if (hold) begin
      @(negedge clk);
      chk("relaunch", 64'(m_busy), 64'd1);
      start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    int macs, we_seen;
    bit hit;
    load(2, 1, 0, 0, 0);
    rand_mem();
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk($sformatf("rst_out%0d", i), outs(), 64'd0);
    end

    run_prog(0, 0);
    chk("busy17", 64'(busy_n), 64'd17);
    if (oq_o.size() == 3) begin
      chk("wr_l0a", 64'(oq_o[0]), 64'd3);
      chk("wr_l0b", 64'(oq_o[1]), 64'd4);
      chk("wr_l1", 64'(oq_o[2]), 64'd5);
    end

    load(0, 0, 0, 0, 0);
    run_prog(0, 0);
    chk("empty_busy", 64'(busy_n), 64'd1);
    chk("empty_we", 64'(oq_o.size()), 64'd0);
    chk("empty_clr", 64'(clr_n), 64'd0);

    load(2, 1, 0, 0, 0);
    run_prog(0, 2);
    chk("start_busy", 64'(busy_n), 64'd17);

    // Abort in the second MAC cycle.
    @(negedge clk);
    start = 1'b1;
    macs = 0; we_seen = 0; hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_we) we_seen++;
      if (m_acc) macs++;
      if (macs == 2) hit = 1;
    end
    chk("mid_reach", 64'(hit), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk("mid_rst", outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m_we || m_busy) we_seen++;
    end
    chk("mid_no_we", 64'(we_seen), 64'd0);
    run_prog(0, 0);
    chk("rerun_busy", 64'(busy_n), 64'd17);

    run_prog(1, 0);

    sel = 1'b1;
    load(1, 0, 0, 0, 0);
    rand_mem();
    run_prog(0, 0);
    if (oq_r.size() == 4) begin
      chk("wrap_rd0", 64'(oq_r[0]), 64'd252);
      chk("wrap_rd3", 64'(oq_r[3]), 64'd255);
    end
    if (oq_o.size() == 1) chk("wrap_wr", 64'(oq_o[0]), 64'd0);

    for (int r = 0; r < 9; r++) begin
      int nl;
      sel = (r >= 6);
      nl = $urandom_range(1, 4);
      load(0, 0, 0, 0, 0);
      for (int l = 0; l < nl; l++) prog[l] = 8'($urandom_range(1, 6));
      rand_mem();
      run_prog(0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
